// File: rtl/decode_stage_p.sv
// Decode stage: IF/ID pipeline register, banked register file with write-through,
// MEM/WB operand forwarding, load-use and branch interlocks, and zero-compare branch resolution.
module decode_stage_p #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned BANK_W    = 1,
  parameter logic [5:0]  NOP_FUNCT = 6'h15,
  localparam int unsigned RA_W     = BANK_W + REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [5:0]        if_opcode,
  input  logic [5:0]        if_funct,
  input  logic [REG_AW-1:0] if_rs1,
  input  logic [REG_AW-1:0] if_rs2,
  input  logic [REG_AW-1:0] if_rd,
  input  logic [15:0]       if_imm,
  input  logic [DATA_W-1:0] if_pc4,
  input  logic              flush,
  input  logic [BANK_W-1:0] id_ctl_bank,
  input  logic              id_ctl_use1,
  input  logic              id_ctl_use2,
  input  logic              id_ctl_br,
  input  logic              id_ctl_bne,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              mem_we,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [5:0]        id_opcode,
  output logic [5:0]        id_funct,
  output logic [15:0]       id_imm,
  output logic [DATA_W-1:0] id_pc4,
  output logic [RA_W-1:0]   id_rs1_addr,
  output logic [RA_W-1:0]   id_rs2_addr,
  output logic [DATA_W-1:0] id_rs1_val,
  output logic [DATA_W-1:0] id_rs2_val,
  output logic [REG_AW-1:0] id_rd,
  output logic              br_taken,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned RF_N = 1 << RA_W;

  logic              v_q;
  logic [5:0]        opcode_q;
  logic [5:0]        funct_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [REG_AW-1:0] rd_q;
  logic [15:0]       imm_q;
  logic [DATA_W-1:0] pc4_q;
  logic [15:0]       stall_q;
  logic [DATA_W-1:0] rf [RF_N];

  logic hit1;
  logic hit2;
  logic haz;

  // WB forwarding also provides the write-through path for same-cycle reads.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [RA_W-1:0]   a,
    input logic [DATA_W-1:0] stored,
    input logic              m_we,
    input logic [RA_W-1:0]   m_rd,
    input logic [DATA_W-1:0] m_d,
    input logic              w_we,
    input logic [RA_W-1:0]   w_a,
    input logic [DATA_W-1:0] w_d
  );
    if (a == '0)                   return '0;
    else if (m_we && (m_rd == a))  return m_d;
    else if (w_we && (w_a == a))   return w_d;
    else                           return stored;
  endfunction

  always_comb begin
    id_rs1_addr = {id_ctl_bank, rs1_q};
    id_rs2_addr = {id_ctl_bank, rs2_q};
    id_rs1_val  = fwd_sel(id_rs1_addr, rf[id_rs1_addr], mem_we, mem_rd, mem_data,
                          wb_we, wb_addr, wb_data);
    id_rs2_val  = fwd_sel(id_rs2_addr, rf[id_rs2_addr], mem_we, mem_rd, mem_data,
                          wb_we, wb_addr, wb_data);
  end

  always_comb begin
    hit1     = id_ctl_use1 && (id_rs1_addr != '0) && (id_rs1_addr == ex_rd);
    hit2     = id_ctl_use2 && (id_rs2_addr != '0) && (id_rs2_addr == ex_rd);
    haz      = v_q && ex_valid && ex_we && (ex_load || id_ctl_br) && (hit1 || hit2);
    id_valid = v_q && !haz && !flush;
    if_ready = !v_q || (ex_ready && !haz);
    br_taken = id_valid && id_ctl_br && ((id_rs1_val != '0) == id_ctl_bne);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v_q      <= 1'b0;
      opcode_q <= '0;
      funct_q  <= NOP_FUNCT;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
    end else if (if_ready) begin
      v_q      <= if_valid;
      opcode_q <= if_opcode;
      funct_q  <= if_funct;
      rs1_q    <= if_rs1;
      rs2_q    <= if_rs2;
      rd_q     <= if_rd;
      imm_q    <= if_imm;
      pc4_q    <= if_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (haz && (stall_q != '1))
      stall_q <= stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wb_we && (wb_addr != '0))
      rf[wb_addr] <= wb_data;
  end

  assign id_opcode = opcode_q;
  assign id_funct  = funct_q;
  assign id_imm    = imm_q;
  assign id_pc4    = pc4_q;
  assign id_rd     = rd_q;
  assign stall_cnt = stall_q;

endmodule
